// File: rtl/if_id_skid_buf_pkg.sv
// Shared definitions for the fetch-to-decode skid buffer: state encoding and
// the WISC NOP instruction word.
package if_id_skid_buf_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam logic [15:0] WISC_NOP = 16'h0800;

endpackage

// File: rtl/skid_entry.sv
// One buffered beat: a W-bit register with load enable and asynchronous
// active-low reset to RST_VAL.
module skid_entry #(
    parameter int            W       = 32,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = ld ? d : data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/if_id_skid_buf.sv
// Two-entry valid/ready skid buffer carrying {pc, instr} from fetch to decode.
// in_ready is a flop, so decode back-pressure never reaches fetch combinationally.
module if_id_skid_buf
    import if_id_skid_buf_pkg::*;
#(
    parameter int             DW        = 16,
    parameter logic [DW-1:0]  NOP_INSTR = DW'(WISC_NOP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_pc,
    input  logic [DW-1:0] in_instr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_pc,
    output logic [DW-1:0] out_instr,
    output logic [1:0]    occ
);

    localparam logic [2*DW-1:0] ENTRY_RST = {{DW{1'b0}}, NOP_INSTR};

    state_e          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            acc_in, acc_out;
    logic            main_ld, skid_ld, main_from_skid;
    logic [2*DW-1:0] main_q, skid_q, main_din, in_beat;

    assign in_beat = {in_pc, in_instr};
    assign acc_in  = in_valid & in_ready_q;
    assign acc_out = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        // Flush suppresses loads too, so out_pc keeps the last delivered pc.
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc_in) begin
                        state_d = ST_ONE;
                        main_ld = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (acc_in && !acc_out) begin
                        state_d = ST_TWO;
                        skid_ld = 1'b1;
                    end else if (acc_out && !acc_in) begin
                        state_d = ST_EMPTY;
                    end else if (acc_in && acc_out) begin
                        main_ld = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (acc_out) begin
                        state_d        = ST_ONE;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_TWO);
    end

    assign main_din = main_from_skid ? skid_q : in_beat;

    skid_entry #(.W(2*DW), .RST_VAL(ENTRY_RST)) u_main (
        .clk (clk),
        .rst (rst),
        .ld  (main_ld),
        .d   (main_din),
        .q   (main_q)
    );

    skid_entry #(.W(2*DW), .RST_VAL(ENTRY_RST)) u_skid (
        .clk (clk),
        .rst (rst),
        .ld  (skid_ld),
        .d   (in_beat),
        .q   (skid_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_pc    = main_q[2*DW-1:DW];
    assign out_instr = out_valid ? main_q[DW-1:0] : NOP_INSTR;
    assign occ       = state_q;

endmodule

// File: tb/tb_if_id_skid_buf.sv
// Scoreboard bench for if_id_skid_buf: accepted beats are queued from the
// stimulus side and compared against the main entry while out_valid is high.
module tb_if_id_skid_buf;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_pc = '0;
    logic [15:0] in_instr = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic [1:0]  occ;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];
    int          occ_m = 0;

    if_id_skid_buf dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("occ", 32'(occ), 32'(occ_m));
        check("in_ready", 32'(in_ready), 32'(occ_m != 2));
        check("out_valid", 32'(out_valid), 32'(occ_m != 0));
        if (occ_m == 0)
            check("nop_instr", 32'(out_instr), 32'(NOP));
        else if (sb.size() > 0)
            check("out_beat", {out_pc, out_instr}, sb[0]);
    endtask

    // Called at a falling edge: check current outputs, drive one cycle, advance model.
    task automatic step(input logic iv, input logic [15:0] pc, input logic ordy, input logic fl);
        logic acc_in_m, acc_out_m;
        in_valid  = iv;
        in_pc     = iv ? pc : 16'hxxxx;
        in_instr  = iv ? (pc ^ 16'h5A00) : 16'hxxxx;
        out_ready = ordy;
        flush     = fl;
        check_outputs();
        acc_in_m  = iv && (occ_m != 2);
        acc_out_m = ordy && (occ_m != 0);
        if (fl) begin
            sb.delete();
            occ_m = 0;
        end else begin
            if (acc_out_m) begin
                void'(sb.pop_front());
                occ_m--;
            end
            if (acc_in_m) begin
                sb.push_back({pc, pc ^ 16'h5A00});
                occ_m++;
            end
        end
        $display("cyc: in_v=%0b pc=%h out_rdy=%0b flush=%0b -> occ_model=%0d", iv, pc, ordy, fl, occ_m);
        @(negedge clk);
    endtask

    initial begin
        // Reset held with in_valid asserted
        in_valid = 1'b1;
        in_pc    = 16'h0002;
        in_instr = 16'h0002 ^ 16'h5A00;
        repeat (3) @(negedge clk);
        check_outputs();
        check("rst_out_pc", 32'(out_pc), 32'h0);
        rst = 1'b1;
        step(1'b1, 16'h0002, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Streaming at one beat per cycle
        for (int i = 0; i < 4; i++)
            step(1'b1, 16'(2 * i), 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);

        // Back-pressure: A held while B fills the skid entry, third beat refused
        step(1'b1, 16'h0010, 1'b0, 1'b0);
        step(1'b1, 16'h0012, 1'b0, 1'b0);
        step(1'b1, 16'h0014, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);

        // Flush while full with a new beat offered
        step(1'b1, 16'h0010, 1'b0, 1'b0);
        step(1'b1, 16'h0012, 1'b0, 1'b0);
        step(1'b1, 16'h0020, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0);

        // Flush coinciding with an output transfer and an input transfer
        step(1'b1, 16'h0030, 1'b0, 1'b0);
        step(1'b1, 16'h0031, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'h0032, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);

        // Random traffic with occasional flushes
        for (int i = 0; i < 200; i++)
            step(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Asynchronous reset between edges while full
        step(1'b1, 16'h0040, 1'b0, 1'b0);
        step(1'b1, 16'h0042, 1'b0, 1'b0);
        check("pre_rst_occ", 32'(occ), 32'd2);
        #2 rst = 1'b0;
        #1;
        check("arst_occ", 32'(occ), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_instr", 32'(out_instr), 32'(NOP));
        check("arst_out_pc", 32'(out_pc), 32'h0);
        sb.delete();
        occ_m = 0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 16'h0050, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
